// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digits needed to represent the largest n-bit unsigned value.
  function automatic int max_digits(input int n);
    longint unsigned v;
    int              d;
    v = (64'd1 << n) - 64'd1;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Add-3 correction for one BCD digit, applied before each left shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Handshake: start is accepted only in IDLE or DONE (bin sampled on that edge);
// busy is high for the N shift cycles; done pulses for one cycle as bcd updates.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   bin,
  output logic [4*D-1:0] bcd,
  output logic           busy,
  output logic           done,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = 4 * D;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("bin2bcd_seq: N=%0d outside 2..16", N);
  end
  if (D < max_digits(N)) begin : g_bad_d
    $error("bin2bcd_seq: D=%0d too small for N=%0d", D, N);
  end

  bcd_state_t    state_q, state_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [SW-1:0] scr_q, scr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] bcd_q, bcd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [SW-1:0] scr_adj;
  logic [SW-1:0] scr_shl;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (scr_adj[4*g +: 4])
    );
  end

  // Scratch takes the next binary bit (MSB first) as the shift register empties.
  assign scr_shl = {scr_adj[SW-2:0], sh_q[N-1]};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          sh_d    = bin;
          scr_d   = '0;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = {sh_q[N-2:0], 1'b0};
        scr_d = scr_shl;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_shl;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bcd       = bcd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq at N=8/D=3 (handshake), N=4/D=2 (exhaustive), N=16/D=5.
module tb_bin2bcd_seq;
  import bcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  logic        start8,  busy8,  done8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;
  logic [1:0]  dbg8;

  logic        start4,  busy4,  done4;
  logic [3:0]  bin4;
  logic [7:0]  bcd4;
  logic [1:0]  dbg4;

  logic        start16, busy16, done16;
  logic [15:0] bin16;
  logic [19:0] bcd16;
  logic [1:0]  dbg16;

  bin2bcd_seq #(.N(8), .D(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .bcd(bcd8), .busy(busy8), .done(done8), .dbg_state(dbg8)
  );

  bin2bcd_seq #(.N(4), .D(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin(bin4),
    .bcd(bcd4), .busy(busy4), .done(done4), .dbg_state(dbg4)
  );

  bin2bcd_seq #(.N(16), .D(5)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16),
    .bcd(bcd16), .busy(busy16), .done(done16), .dbg_state(dbg16)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp8_q[$];
  logic [7:0]  exp4_q[$];
  logic [19:0] exp16_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (exp8_q.size() == 0) check("bcd8_unexpected_done", 32'(bcd8), 32'hFFFF_FFFF);
      else check("bcd8_value", 32'(bcd8), 32'(exp8_q.pop_front()));
    end
    if (!rst && done4) begin
      if (exp4_q.size() == 0) check("bcd4_unexpected_done", 32'(bcd4), 32'hFFFF_FFFF);
      else check("bcd4_value", 32'(bcd4), 32'(exp4_q.pop_front()));
    end
    if (!rst && done16) begin
      if (exp16_q.size() == 0) check("bcd16_unexpected_done", 32'(bcd16), 32'hFFFF_FFFF);
      else check("bcd16_value", 32'(bcd16), 32'(exp16_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic done_of(input int w);
    case (w)
      0:       return done8;
      1:       return done4;
      default: return done16;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy8;
      1:       return busy4;
      default: return busy16;
    endcase
  endfunction

  // Called just after the accepting edge; cycle 1 is the one that follows it.
  task automatic wait_done(input int w, input int exp_lat, input int exp_busy, input string name);
    int  lat;
    int  busy_cyc;
    bit  seen;
    lat = 0;
    busy_cyc = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done_of(w)) seen = 1'b1;
      else if (busy_of(w)) busy_cyc++;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    end
  endtask

  task automatic convert8(input logic [7:0] v, input logic [11:0] exp, input string name);
    exp8_q.push_back(exp);
    @(posedge clk); #2;
    start8 = 1'b1;
    bin8   = v;
    @(posedge clk); #2;
    start8 = 1'b0;
    bin8   = ~v;  // bin must be ignored once the conversion is accepted
    wait_done(0, 9, 8, name);
  endtask

  task automatic convert4(input logic [3:0] v, input logic [7:0] exp);
    exp4_q.push_back(exp);
    @(posedge clk); #2;
    start4 = 1'b1;
    bin4   = v;
    @(posedge clk); #2;
    start4 = 1'b0;
    wait_done(1, 5, 4, "n4");
  endtask

  task automatic convert16(input logic [15:0] v, input logic [19:0] exp);
    exp16_q.push_back(exp);
    @(posedge clk); #2;
    start16 = 1'b1;
    bin16   = v;
    @(posedge clk); #2;
    start16 = 1'b0;
    wait_done(2, 17, 16, "n16");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d1, d2, t, viol, n_done;
    logic [7:0] e4;

    rst = 1'b1;
    start8 = 1'b0;  bin8 = '0;
    start4 = 1'b0;  bin4 = '0;
    start16 = 1'b0; bin16 = '0;
    #23 rst = 1'b0;

    @(negedge clk);
    check("reset_bcd8",   32'(bcd8),  32'h0);
    check("reset_busy8",  32'(busy8), 32'h0);
    check("reset_done8",  32'(done8), 32'h0);
    check("reset_state8", 32'(dbg8),  32'(IDLE));

    // Max value, then output must hold in IDLE.
    convert8(8'd255, 12'h255, "b255");
    repeat (5) @(negedge clk);
    check("hold_bcd8",   32'(bcd8), 32'h255);
    check("hold_state8", 32'(dbg8), 32'(IDLE));

    convert8(8'd0,   12'h000, "b0");
    convert8(8'd100, 12'h100, "b100");
    convert8(8'd9,   12'h009, "b9");
    convert8(8'd10,  12'h010, "b10");

    // Start during SHIFT cycle 3 must be ignored.
    exp8_q.push_back(12'h037);
    @(posedge clk); #2; start8 = 1'b1; bin8 = 8'd37;
    @(posedge clk); #2; start8 = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2; start8 = 1'b1; bin8 = 8'd200;
    @(posedge clk); #2; start8 = 1'b0;
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    check("ignored_start_done_count", 32'(n_done), 32'd1);
    check("ignored_start_bcd8", 32'(bcd8), 32'h037);

    // start held high: back-to-back conversions 57 then 198.
    exp8_q.push_back(12'h057);
    exp8_q.push_back(12'h198);
    @(posedge clk); #2; start8 = 1'b1; bin8 = 8'd57;
    @(posedge clk); #2; bin8 = 8'd198;
    t = 0; d1 = -1; d2 = -1; viol = 0;
    while (t < 60 && d2 < 0) begin
      @(negedge clk);
      t++;
      if (busy8 == done8) viol++;
      if (done8) begin
        if (d1 < 0) begin
          d1 = t;
          @(posedge clk); #2;
          start8 = 1'b0;
        end else begin
          d2 = t;
        end
      end
    end
    check("b2b_first_done_cycle", 32'(d1), 32'd9);
    check("b2b_period", 32'(d2 - d1), 32'd9);
    check("b2b_busy_xor_done_violations", 32'(viol), 32'd0);
    check("b2b_final_bcd8", 32'(bcd8), 32'h198);

    // Asynchronous reset in the middle of a conversion.
    @(posedge clk); #2; start8 = 1'b1; bin8 = 8'd99;
    @(posedge clk); #2; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_bcd8",   32'(bcd8),  32'h0);
    check("async_rst_busy8",  32'(busy8), 32'h0);
    check("async_rst_done8",  32'(done8), 32'h0);
    check("async_rst_state8", 32'(dbg8),  32'(IDLE));
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (15) @(negedge clk);
    check("after_rst_bcd8", 32'(bcd8), 32'h0);
    convert8(8'd42, 12'h042, "b42");

    // N=4, D=2: exhaustive against a decimal model.
    for (int v = 0; v < 16; v++) begin
      e4 = {4'(v / 10), 4'(v % 10)};
      convert4(4'(v), e4);
    end
    check("n4_max_bcd4", 32'(bcd4), 32'h15);

    // N=16, D=5: full-scale value.
    convert16(16'hFFFF, 20'h65535);

    repeat (3) @(negedge clk);
    check("q8_drained",  32'(exp8_q.size()),  32'd0);
    check("q4_drained",  32'(exp4_q.size()),  32'd0);
    check("q16_drained", 32'(exp16_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
